// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - utilisation encoding and quartile helper shared by the FIFO
package fifo_pkg;

  localparam logic [1:0] UTIL_Q0 = 2'd0;
  localparam logic [1:0] UTIL_Q1 = 2'd1;
  localparam logic [1:0] UTIL_Q2 = 2'd2;
  localparam logic [1:0] UTIL_Q3 = 2'd3;

  // DEPTH is a power of two >= 4, so every quartile boundary is an exact integer
  function automatic logic [1:0] util_of(input int unsigned level, input int unsigned depth);
    logic [1:0] q;
    if (level < depth / 4)
      q = UTIL_Q0;
    else if (level < depth / 2)
      q = UTIL_Q1;
    else if (level < (3 * depth) / 4)
      q = UTIL_Q2;
    else
      q = UTIL_Q3;
    return q;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// rtl/fifo_regfile.sv - sample storage, synchronous write, asynchronous read
module fifo_regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock sample FIFO with reserve threshold, peek and sticky errors
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW:0]      reserve,
  input  logic [WIDTH-1:0] data_put,
  input  logic             req_put,
  output logic             not_full,
  output logic             full,
  output logic [WIDTH-1:0] data_get,
  input  logic             req_get,
  input  logic             nap,
  output logic             empty,
  output logic [AW:0]      level,
  output logic [1:0]       fifo_util,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             ovf_q;
  logic             udf_q;
  logic [WIDTH-1:0] rd_data;
  logic [AW:0]      reserve_eff;
  logic             pop;
  logic             push;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // a write into a full FIFO is only taken when the head leaves in the same cycle
  assign pop  = req_get & ~empty & ~nap;
  assign push = req_put & (~full | pop);

  assign reserve_eff = (reserve >= DEPTH_C) ? DEPTH_C : reserve;
  assign not_full    = (count < (DEPTH_C - reserve_eff));

  assign level     = count;
  assign fifo_util = util_of(32'(count), 32'(DEPTH));
  assign data_get  = empty ? '0 : rd_data;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase

      // setting a flag takes priority over clearing it in the same cycle
      if (req_put & ~push)
        ovf_q <= 1'b1;
      else if (clear_err)
        ovf_q <= 1'b0;

      if (req_get & ~nap & empty)
        udf_q <= 1'b1;
      else if (clear_err)
        udf_q <= 1'b0;
    end
  end

  fifo_regfile #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (push & reset),
    .waddr (wr_ptr),
    .wdata (data_put),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised successor to the mixed-clock sample FIFO used in the FIR audio path. It buffers WIDTH-bit samples in DEPTH entries. Features:
- programmable reserve threshold;
- quantised utilisation output for DVFS;
- nap (peek without pop);
- exact fill level;
- sticky overflow/underflow error flags.

It sits between the sample source and the FIR core where both run on one clock.

Parameters:
WIDTH, 32, sample width in bits.
DEPTH, 16, number of entries; power of 2, >= 4.
AW, $clog2(DEPTH), derived localparam; pointer width. Not overridable.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
reserve  in  AW+1  reserve-space constant in entries; held static during operation.
data_put  in  WIDTH  write data.
req_put  in  1  write request.
not_full  out  1  1 = level < DEPTH - min(reserve, DEPTH); 0 = full or inside reserve.
full  out  1  1 = level == DEPTH.
data_get  out  WIDTH  head entry (first-word-fall-through); 0 when empty.
req_get  in  1  read request.
nap  in  1  1 = suppress pointer advance on read (peek).
empty  out  1  1 = level == 0.
level  out  AW+1  current occupancy, 0..DEPTH.
fifo_util  out  2  quantised occupancy.
overflow  out  1  sticky: a write was refused.
underflow  out  1  sticky: a pop was attempted while empty.
clear_err  in  1  clears overflow/underflow.

Behaviour:
- State: storage array, wr_ptr[AW-1:0], rd_ptr[AW-1:0], count[AW:0], overflow, underflow. All outputs are combinational functions of these registers only; none depends on same-cycle inputs.
- Reset (reset==0 at edge), including mid-operation:
  - wr_ptr, rd_ptr and count return to 0; overflow and underflow return to 0.
  - Storage contents are not cleared.
  - Outputs after reset: empty=1, full=0, level=0, fifo_util=0, data_get=0, overflow=0, underflow=0, not_full=(reserve<DEPTH).
- Pop: pop = req_get & ~empty & ~nap.
  - rd_ptr advances by 1, modulo DEPTH.
  - data_get shows the new head in the next cycle.
- Push: push = req_put & (count<DEPTH | pop).
  - A write into a full FIFO is accepted only when a pop occurs in the same cycle.
  - Data is written at wr_ptr; wr_ptr advances by 1, modulo DEPTH.
- count update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Pointer wrap is natural AW-bit wrap; count disambiguates full from empty.
- Write latency: data written in cycle N appears on data_get in N+1 if the FIFO was empty. empty deasserts in N+1.
- nap=1: head remains visible on data_get and no state changes on the read side. nap has no effect on the write side.
- not_full is driven from the registered count and reserve.
  - reserve >= DEPTH: not_full is constantly 0.
  - reserve=0: not_full = ~full.
  - Writes while not_full=0 but count<DEPTH are still accepted (reserve space is usable).
- fifo_util:
  - 0 when level < DEPTH/4.
  - 1 when level < DEPTH/2.
  - 2 when level < 3*DEPTH/4.
  - 3 otherwise.
- Error flags:
  - overflow sets when req_put=1 and push=0.
  - underflow sets when req_get=1, nap=0 and empty=1.
  - clear_err clears both flags the next cycle. Set wins over clear in the same cycle.
- No X propagation: data_get is forced to 0 while empty=1.

Decomposition:
- Package fifo_pkg holds:
  - util encoding constants UTIL_Q0..UTIL_Q3 (2'd0..2'd3);
  - a quartile-threshold function util_of(level, DEPTH).
- One sub-module, fifo_regfile (WIDTH, DEPTH): synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata). Pointers, count and flags stay in sync_fifo_param.

Test Plan:
- Reset then fill, DEPTH=16, reserve=4: write 0x00000001..0x00000010 on 16 consecutive cycles.
  - not_full falls after the 12th write (level=12).
  - full=1 after the 16th write; fifo_util=3.
  - A 17th req_put sets overflow=1 and level stays 16.
- Drain in order: from full, req_get=1 for 16 cycles.
  - data_get sequence is 0x1..0x10.
  - empty=1 after the last pop.
  - A further req_get sets underflow=1; clear_err=1 clears it the next cycle.
- Simultaneous push and pop at full: level=16, req_put=req_get=1 with data 0xDEADBEEF.
  - level stays 16, overflow stays 0.
  - 0xDEADBEEF is read out 16 pops later.
- Nap/peek: level=3, head=0xA5A5A5A5, nap=1, req_get=1 for 5 cycles.
  - data_get holds 0xA5A5A5A5 and level stays 3.
  - Dropping nap pops on the next edge.
- Wrap-around and utilisation: 100 000 random push/pop cycles at the 44:16 put/get rate ratio, checked against a scoreboard.
  - Data order matches the scoreboard.
  - fifo_util boundaries hold: level 3→0, 4→1, 8→2, 12→3.
- Mid-operation reset: level=9, reset=0 for one cycle.
  - Next cycle: empty=1, level=0, data_get=0, flags=0.
  - A subsequent write of 0x12345678 reads back correctly.
